// File: rtl/mult_resp_pkg.sv
// Shared types, window slice positions and helpers for the multiplier response compactor.
package mult_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned F_W   = 128;
    localparam int unsigned WIN_W = 28;

    localparam int unsigned SL_HI_MSB  = 127;
    localparam int unsigned SL_HI_LSB  = 112;
    localparam int unsigned SL_M1_MSB  = 67;
    localparam int unsigned SL_M1_LSB  = 64;
    localparam int unsigned SL_M0_MSB  = 35;
    localparam int unsigned SL_M0_LSB  = 32;
    localparam int unsigned SL_LO_MSB  = 3;
    localparam int unsigned SL_LO_LSB  = 0;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0000;

    // Window word, MSB first: top product slice, then the three nibble slices.
    function automatic logic [WIN_W-1:0] win_extract(input logic [F_W-1:0] f);
        return {f[SL_HI_MSB:SL_HI_LSB], f[SL_M1_MSB:SL_M1_LSB],
                f[SL_M0_MSB:SL_M0_LSB], f[SL_LO_MSB:SL_LO_LSB]};
    endfunction

endpackage

// File: rtl/mult_resp_compactor_misr_reg.sv
// Multiple-input signature register: shift-left with feedback taps on MSB, XOR in data.
module misr_reg
    import mult_resp_pkg::*;
#(
    parameter int unsigned        MISR_W = 32,
    parameter logic [MISR_W-1:0]  POLY   = MISR_W'(DEFAULT_POLY),
    parameter logic [MISR_W-1:0]  SEED   = MISR_W'(DEFAULT_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [MISR_W-1:0] data_in,
    output logic [MISR_W-1:0] sig,
    output logic [MISR_W-1:0] sig_next_c
);

    always_comb begin
        sig_next_c = {sig[MISR_W-2:0], 1'b0} ^ data_in;
        if (sig[MISR_W-1]) begin
            sig_next_c = sig_next_c ^ POLY;
        end
    end

    // Load has priority so a restart never folds in a coincident sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next_c;
        end
    end

endmodule

// File: rtl/mult_resp_compactor.sv
// Reduces product vectors to window words, compacts them into a MISR and grades the final signature.
module mult_resp_compactor
    import mult_resp_pkg::*;
#(
    parameter int unsigned        STEPS  = 256,
    parameter int unsigned        MISR_W = 32,
    parameter logic [MISR_W-1:0]  POLY   = MISR_W'(DEFAULT_POLY),
    parameter logic [MISR_W-1:0]  SEED   = MISR_W'(DEFAULT_SEED),
    localparam int unsigned       CNT_W  = $clog2(STEPS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [F_W-1:0]    f_vec,
    input  logic              f_valid,
    output logic              f_ready,
    input  logic [MISR_W-1:0] golden_sig,
    output logic [WIN_W-1:0]  win_word,
    output logic              win_valid,
    output logic [MISR_W-1:0] signature,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic              done,
    output logic              pass
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STEPS - 1);

    state_t              state_q;
    state_t              state_d;
    logic                accept_c;
    logic                last_c;
    logic [WIN_W-1:0]    win_c;
    logic [MISR_W-1:0]   sig_next_c;

    assign win_c = win_extract(f_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start from any state (re)opens a run; a sample on the start edge is dropped.
    always_comb begin
        state_d  = state_q;
        f_ready  = 1'b0;
        accept_c = 1'b0;
        last_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                f_ready = 1'b1;
                if (!start && f_valid) begin
                    accept_c = 1'b1;
                    if (sample_cnt == LAST_IDX) begin
                        last_c  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
            win_word   <= '0;
            win_valid  <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            if (start) begin
                sample_cnt <= '0;
                win_word   <= '0;
                done       <= 1'b0;
                pass       <= 1'b0;
            end else if (accept_c) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
                win_word   <= win_c;
                win_valid  <= 1'b1;
                if (last_c) begin
                    done <= 1'b1;
                    pass <= (sig_next_c == golden_sig);
                end
            end
        end
    end

    misr_reg #(
        .MISR_W (MISR_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clk        (clk),
        .rst        (rst),
        .load       (start),
        .en         (accept_c),
        .data_in    (MISR_W'(win_c)),
        .sig        (signature),
        .sig_next_c (sig_next_c)
    );

endmodule

// File: tb/tb_mult_resp_compactor.sv
// Randomized self-checking bench for mult_resp_compactor against a behavioural MISR model.
module tb_mult_resp_compactor;

    localparam logic [31:0] P = 32'h04C1_1DB7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] f_vec = '0;
    logic         f_valid = 1'b0;
    logic [31:0]  golden_sig = '0;
    logic         start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    logic         ready_a, ready_b, ready_c;
    logic [27:0]  win_a, win_b, win_c;
    logic         wv_a, wv_b, wv_c;
    logic [31:0]  sig_a, sig_b, sig_c;
    logic [8:0]   cnt_a, cnt_c;
    logic [0:0]   cnt_b;
    logic         done_a, done_b, done_c;
    logic         pass_a, pass_b, pass_c;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] samp [256];

    always #5 clk = ~clk;

    mult_resp_compactor dut_a (
        .clk(clk), .rst(rst), .start(start_a), .f_vec(f_vec), .f_valid(f_valid),
        .f_ready(ready_a), .golden_sig(golden_sig), .win_word(win_a), .win_valid(wv_a),
        .signature(sig_a), .sample_cnt(cnt_a), .done(done_a), .pass(pass_a));

    mult_resp_compactor #(.STEPS(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .f_vec(f_vec), .f_valid(f_valid),
        .f_ready(ready_b), .golden_sig(golden_sig), .win_word(win_b), .win_valid(wv_b),
        .signature(sig_b), .sample_cnt(cnt_b), .done(done_b), .pass(pass_b));

    mult_resp_compactor #(.SEED(32'h8000_0000)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .f_vec(f_vec), .f_valid(f_valid),
        .f_ready(ready_c), .golden_sig(golden_sig), .win_word(win_c), .win_valid(wv_c),
        .signature(sig_c), .sample_cnt(cnt_c), .done(done_c), .pass(pass_c));

    // Reference: window assembled with shifts/masks, MISR step with modular arithmetic.
    function automatic logic [27:0] ref_win(input logic [127:0] f);
        logic [127:0] t;
        t = ((f >> 112) << 12) | (((f >> 64) & 128'hF) << 8)
          | (((f >> 32) & 128'hF) << 4) | (f & 128'hF);
        return t[27:0];
    endfunction

    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [27:0] w);
        logic [31:0] r;
        r = s * 32'd2;
        if (s >= 32'h8000_0000) r = r ^ P;
        return r ^ {4'h0, w};
    endfunction

    function automatic logic [31:0] ref_sig(input int n, input logic [31:0] seed,
                                            input int flip_idx, input int flip_bit);
        logic [31:0]  s;
        logic [127:0] v;
        s = seed;
        for (int i = 0; i < n; i++) begin
            v = samp[i];
            if (i == flip_idx) v[flip_bit] = ~v[flip_bit];
            s = ref_step(s, ref_win(v));
        end
        return s;
    endfunction

    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 0) start_a = 1'b1; else if (which == 1) start_b = 1'b1; else start_c = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    // Drives samp[0..n-1] back to back or with random idle gaps (X on the bus while idle).
    task automatic feed(input int n, input bit gaps, input int flip_idx, input int flip_bit);
        logic [127:0] v;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                    @(negedge clk);
                    f_valid = 1'b0;
                    f_vec   = 'x;
                end
            end
            v = samp[i];
            if (i == flip_idx) v[flip_bit] = ~v[flip_bit];
            @(negedge clk);
            f_vec   = v;
            f_valid = 1'b1;
        end
        @(negedge clk);
        f_valid = 1'b0;
        f_vec   = '0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) samp[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({sig_a, cnt_a, win_a, wv_a, done_a, pass_a, ready_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: sig=%h cnt=%0d win=%h wv=%b done=%b pass=%b rdy=%b want all 0",
                     sig_a, cnt_a, win_a, wv_a, done_a, pass_a, ready_a);
        end
        n_tests++;
        if (sig_c !== 32'h8000_0000) begin
            n_fail++; $display("FAIL reset_seed: sig=%h want 80000000", sig_c);
        end
    endtask

    task automatic test_zero_run();
        for (int i = 0; i < 256; i++) samp[i] = '0;
        golden_sig = '0;
        pulse_start(0);
        n_tests++;
        if (ready_a !== 1'b1) begin n_fail++; $display("FAIL run_ready: got %b want 1", ready_a); end
        feed(256, 1'b0, -1, 0);
        n_tests++;
        if ({sig_a, cnt_a, done_a, pass_a, ready_a} !== {32'h0, 9'd256, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_run: sig=%h cnt=%0d done=%b pass=%b rdy=%b want 0/256/1/1/0",
                     sig_a, cnt_a, done_a, pass_a, ready_a);
        end
    endtask

    task automatic test_single_bit();
        pulse_start(0);
        n_tests++;
        if ({done_a, pass_a, cnt_a} !== '0) begin
            n_fail++; $display("FAIL restart_clear: done=%b pass=%b cnt=%0d want 0", done_a, pass_a, cnt_a);
        end
        f_vec = 128'h1; f_valid = 1'b1;
        n_tests++;
        if (wv_a !== 1'b0) begin n_fail++; $display("FAIL wv_early: got %b want 0", wv_a); end
        @(negedge clk);
        f_valid = 1'b0; f_vec = '0;
        n_tests++;
        if ({wv_a, win_a, sig_a} !== {1'b1, 28'h000_0001, 32'h1}) begin
            n_fail++; $display("FAIL single_bit: wv=%b win=%h sig=%h want 1/0000001/00000001", wv_a, win_a, sig_a);
        end
        @(negedge clk);
        n_tests++;
        if (wv_a !== 1'b0) begin n_fail++; $display("FAIL wv_width: got %b want 0", wv_a); end
    endtask

    task automatic test_seed();
        pulse_start(2);
        f_vec = '0; f_valid = 1'b1;
        @(negedge clk);
        f_valid = 1'b0;
        n_tests++;
        if (sig_c !== 32'h04C1_1DB7 || cnt_c !== 9'd1) begin
            n_fail++; $display("FAIL seed_step: sig=%h cnt=%0d want 04c11db7/1", sig_c, cnt_c);
        end
    endtask

    task automatic test_steps1();
        logic [127:0] ones;
        ones = '1;
        for (int k = 0; k < 2; k++) begin
            golden_sig = (k == 0) ? 32'h0FFF_FFFF : 32'h0FFF_FFFE;
            pulse_start(1);
            f_vec = ones; f_valid = 1'b1;
            @(negedge clk);
            f_valid = 1'b0; f_vec = '0;
            n_tests++;
            if ({win_b, done_b, pass_b, cnt_b, ready_b} !== {28'hFFF_FFFF, 1'b1, (k == 0), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL steps1_%0d: win=%h done=%b pass=%b cnt=%0d rdy=%b want fffffff/1/%0d/1/0",
                         k, win_b, done_b, pass_b, cnt_b, ready_b, (k == 0));
            end
        end
    endtask

    task automatic test_random_run();
        logic [31:0] good, bad;
        int fb;
        fill_random();
        good = ref_sig(256, 32'h0, -1, 0);
        golden_sig = good;
        pulse_start(0);
        feed(256, 1'b0, -1, 0);
        n_tests++;
        if ({sig_a, pass_a, done_a} !== {good, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL rand_run: sig=%h pass=%b done=%b want %h/1/1", sig_a, pass_a, done_a, good);
        end
        fb = 112 + int'($urandom_range(0, 15));
        bad = ref_sig(256, 32'h0, 100, fb);
        pulse_start(0);
        feed(256, 1'b0, 100, fb);
        n_tests++;
        if ({sig_a, pass_a} !== {bad, 1'b0}) begin
            n_fail++; $display("FAIL rand_flip: sig=%h pass=%b want %h/0", sig_a, pass_a, bad);
        end
        pulse_start(0);
        feed(256, 1'b1, -1, 0);
        n_tests++;
        if ({sig_a, cnt_a, pass_a} !== {good, 9'd256, 1'b1}) begin
            n_fail++; $display("FAIL rand_gaps: sig=%h cnt=%0d pass=%b want %h/256/1", sig_a, cnt_a, pass_a, good);
        end
        // Samples offered after DONE must not disturb the held result.
        feed(5, 1'b0, -1, 0);
        n_tests++;
        if ({sig_a, cnt_a, done_a, pass_a} !== {good, 9'd256, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL after_done: sig=%h cnt=%0d done=%b pass=%b want %h/256/1/1",
                               sig_a, cnt_a, done_a, pass_a, good);
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] good;
        fill_random();
        good = ref_sig(256, 32'h0, -1, 0);
        golden_sig = good;
        pulse_start(0);
        feed(50, 1'b0, -1, 0);
        n_tests++;
        if (cnt_a !== 9'd50 || sig_a !== ref_sig(50, 32'h0, -1, 0)) begin
            n_fail++; $display("FAIL partial_50: cnt=%0d sig=%h want 50/%h", cnt_a, sig_a, ref_sig(50, 32'h0, -1, 0));
        end
        @(negedge clk);
        rst = 1'b1; start_a = 1'b1; f_valid = 1'b1; f_vec = samp[0];
        @(negedge clk);
        rst = 1'b0; start_a = 1'b0; f_valid = 1'b0;
        n_tests++;
        if ({sig_a, cnt_a, win_a, wv_a, done_a, pass_a, ready_a} !== '0) begin
            n_fail++; $display("FAIL mid_reset: sig=%h cnt=%0d win=%h wv=%b done=%b pass=%b rdy=%b want all 0",
                               sig_a, cnt_a, win_a, wv_a, done_a, pass_a, ready_a);
        end
        pulse_start(0);
        feed(256, 1'b0, -1, 0);
        n_tests++;
        if ({sig_a, pass_a} !== {good, 1'b1}) begin
            n_fail++; $display("FAIL post_reset_run: sig=%h pass=%b want %h/1", sig_a, pass_a, good);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] good;
        fill_random();
        good = ref_sig(256, 32'h0, -1, 0);
        golden_sig = good;
        pulse_start(0);
        feed(30, 1'b0, -1, 0);
        @(negedge clk);
        start_a = 1'b1; f_valid = 1'b1; f_vec = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start_a = 1'b0; f_valid = 1'b0;
        n_tests++;
        if ({cnt_a, sig_a, ready_a} !== {9'd0, 32'h0, 1'b1}) begin
            n_fail++; $display("FAIL restart_30: cnt=%0d sig=%h rdy=%b want 0/00000000/1", cnt_a, sig_a, ready_a);
        end
        feed(256, 1'b0, -1, 0);
        n_tests++;
        if ({sig_a, cnt_a, pass_a, done_a} !== {good, 9'd256, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL restart_run: sig=%h cnt=%0d pass=%b done=%b want %h/256/1/1",
                               sig_a, cnt_a, pass_a, done_a, good);
        end
    endtask

    initial begin
        test_reset();
        test_zero_run();
        test_single_bit();
        test_seed();
        test_steps1();
        test_random_run();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_resp_compactor.md
Name: mult_resp_compactor

Overview:
Downstream response stage for the 64x64 gate-level multiplier (128-bit product f). Each accepted product vector is reduced to a 28-bit window word from four product slices. The word is folded into a 32-bit MISR signature, and the final signature is compared against a golden value. Results feed the fault-sensitivity ranker: a faulty netlist shows up as a signature mismatch after STEPS samples.

Parameters:
STEPS, 256, number of samples per run (>=1)
MISR_W, 32, signature width (>=28)
POLY, 32'h04C11DB7, MISR feedback polynomial (taps applied when MSB=1)
SEED, 32'h00000000, MISR value loaded on start

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse: begin a new run
f_vec  in  128  multiplier product under test
f_valid  in  1  f_vec is valid this cycle
f_ready  out  1  compactor accepts a sample this cycle
golden_sig  in  MISR_W  expected final signature, sampled at the DONE transition
win_word  out  28  window word of the last accepted sample
win_valid  out  1  one-cycle pulse: win_word updated
signature  out  MISR_W  current MISR value
sample_cnt  out  9  samples accepted in the current run (clog2(STEPS)+1)
done  out  1  run complete, held
pass  out  1  valid when done=1: signature == golden_sig

Behaviour:
- Reset values: all outputs 0; signature=SEED; FSM=IDLE. Reset wins over every other input on the same edge, including mid-run.
- FSM states:
  - IDLE: f_ready=0. On start -> RUN, load signature=SEED, clear sample_cnt and win_word.
  - RUN: f_ready=1. A sample is accepted when f_valid&&f_ready.
  - DONE: f_ready=0; done=1 and pass held. On start -> RUN, with the same loads as from IDLE and done/pass cleared.
- Start while in RUN: restart the run (reload SEED, clear counter). Any sample presented on that edge is dropped.
- Window word is formed by concatenation, MSB first: win_word = {f_vec[127:112], f_vec[67:64], f_vec[35:32], f_vec[3:0]}.
- On acceptance:
  - win_word is registered; win_valid pulses 1 cycle later (1-cycle latency).
  - MISR update: next = ({sig[MISR_W-2:0],1'b0} ^ (sig[MISR_W-1] ? POLY : 0)) ^ zero_ext(win_word).
  - sample_cnt increments.
- On the acceptance where sample_cnt==STEPS-1:
  - Transition to DONE on the same edge.
  - signature takes its final value on that edge; done=1 from the next cycle.
  - pass = (final next value == golden_sig), registered on that edge.
- Samples with f_valid=1 outside RUN are ignored; signature and counter are unchanged.
- X on f_vec while f_valid=0 must not propagate into the state.
- f_ready is combinational from FSM state only.

Decomposition:
- Package mult_resp_pkg holds:
  - FSM state enum (IDLE, RUN, DONE).
  - Window slice constants (127:112, 67:64, 35:32, 3:0).
  - WIN_W=28.
  - Default POLY and SEED.
  - A function win_extract(f_vec) returning the 28-bit word.
- One sub-module, misr_reg: MISR_W-wide register with load/enable/data_in, parameterised by POLY.
- The FSM and counter stay in the top module.

Test Plan:
- Reset then start; 256 samples of f_vec=0, SEED=0, golden_sig=0 -> signature 0x00000000, sample_cnt=256, done=1, pass=1, f_ready=0.
- Start; one sample with f_vec[0]=1 only -> win_word=0x0000001, signature=0x00000001, win_valid pulses exactly 1 cycle after acceptance.
- With SEED=0x80000000, start; one sample with f_vec=0 -> signature=0x04C11DB7.
- f_vec=all ones -> win_word=0xFFFFFFF. STEPS=1, golden_sig=0x0FFFFFFF -> done=1, pass=1. Same run with golden_sig=0x0FFFFFFE -> pass=0.
- Run with 256 random products; golden_sig from the reference model; flip one product bit at sample 100 -> pass=0. Separately, f_valid deasserted for random gaps -> sample_cnt and signature match the gap-free run.
- rst asserted after 50 samples -> all outputs 0, signature=SEED; then start with the same samples and the new run result is unaffected. start pulsed at sample 30 -> sample_cnt=0 and signature=SEED next cycle.
